atm_txn_arbiter: RTL and testbench
==================================

Name: atm_txn_arbiter

Overview:
- Serialises balance transactions from N_TERM ATM front-ends onto one shared single-port balance memory (one entry per account).
- Grants one terminal at a time, round-robin.
- Performs the read-modify-write for BALANCE, WITHDRAW and DEPOSIT, then returns the resulting balance and a status to the granted terminal.
- Sits between the ATM session FSMs and the balance store, so concurrent terminals cannot corrupt a balance.

Parameters:
- N_TERM, 2, number of requesting terminals (2..8).
- ACC_COUNT, 10, number of valid accounts; index >= ACC_COUNT is invalid.
- BAL_W, 32, balance/amount width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_TERM  per-terminal request level; held until own done.
- op  in  2*N_TERM  per-terminal op, slice i = op[2i+1:2i]. Encoding: 0 BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 reserved.
- acc  in  4*N_TERM  per-terminal account index, slice i = acc[4i+3:4i].
- amount  in  BAL_W*N_TERM  per-terminal amount; ignored for BALANCE.
- grant  out  N_TERM  one-hot; owner of the current transaction.
- done  out  N_TERM  one-cycle completion pulse to the owner.
- resp_status  out  2  0 OK, 1 INSUFFICIENT, 2 OVERFLOW, 3 BAD_REQ; valid while done != 0.
- resp_balance  out  BAL_W  resulting balance; valid while done != 0.
- busy  out  1  high in every state except IDLE.
- mem_rd_en  out  1  read strobe.
- mem_wr_en  out  1  write strobe.
- mem_addr  out  4  account index for read/write.
- mem_wr_data  out  BAL_W  new balance.
- mem_rd_data  in  BAL_W  synchronous read data, valid the cycle after mem_rd_en.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer set so terminal 0 has highest priority.
  - Any in-flight transaction is dropped; no mem_wr_en is issued for it.
- State IDLE:
  - Eligible = req minus any terminal whose done was high the previous cycle.
  - If none eligible, stay in IDLE.
  - Otherwise pick the first eligible terminal searching from last_grant+1 upward, wrapping. Latch its op, acc and amount; set grant one-hot.
  - If the latched acc >= ACC_COUNT or op == 3, go to RESP with status BAD_REQ and resp_balance 0.
  - Otherwise go to READ.
- State READ: mem_rd_en=1, mem_addr=acc; go to EXEC.
- State EXEC: mem_rd_data is valid.
  - BALANCE: result = rd; status OK; go to RESP.
  - WITHDRAW, amount <= rd: new = rd - amount; go to WRITE.
  - WITHDRAW, amount > rd: status INSUFFICIENT; result = rd; go to RESP.
  - DEPOSIT: form sum in BAL_W+1 bits. If carry set, status OVERFLOW, result = rd, go to RESP; else new = sum, go to WRITE.
  - Withdraw of amount == rd is legal; result 0.
- State WRITE: mem_wr_en=1, mem_addr=acc, mem_wr_data=new; result = new; status OK; go to RESP.
- State RESP:
  - done[g]=1 for exactly one cycle; resp_status and resp_balance driven.
  - last_grant = g; grant cleared on exit; go to IDLE.
  - resp_status and resp_balance read 0 when done is 0.
- Grant timing: grant is asserted from the cycle after the IDLE sample through RESP inclusive.
- Latency (request sampled at edge T in IDLE):
  - BAD_REQ: done at T+1.
  - BALANCE, INSUFFICIENT, OVERFLOW: done at T+3.
  - Successful WITHDRAW/DEPOSIT: done at T+4.
- Throughput: one transaction per 4–5 cycles; back-to-back from different terminals with no idle bubble beyond the IDLE cycle.
- Requests: deasserting req while granted has no effect; the transaction completes and done still pulses. Operand changes after the latch are ignored.
- Memory: at most one of mem_rd_en/mem_wr_en high per cycle; neither high in IDLE, EXEC or RESP. This ordering guarantees no read-after-write hazard between consecutive transactions.

Test Plan:
- BALANCE: term0 requests acc 2, memory holds 3000 → mem_rd_en at T+1 with addr 2; done[0] at T+3; status 0; balance 3000; no mem_wr_en.
- WITHDRAW 500, acc 0 = 1000 → mem_wr_en at T+3 with data 500; done at T+4, status 0, balance 500. Then WITHDRAW 600 → status 1, balance 500, no write. WITHDRAW 500 → balance 0, status 0.
- DEPOSIT 1 to acc holding 0xFFFFFFFF → status 2, balance 0xFFFFFFFF, no write. DEPOSIT 0xFFFFFFFF to acc holding 0 → status 0, write 0xFFFFFFFF.
- Contention: term0 and term1 request together after reset, each DEPOSIT 100 to acc 5 = 6000 → term0 served first (balance 6100), then term1 (balance 6200). Continuous re-requests alternate grants 0,1,0,1. A sole requester re-raising req immediately is served again after one IDLE cycle.
- acc 10, or op 3 → done at T+1, status 3, balance 0; no mem_rd_en/mem_wr_en.
- Reset asserted in EXEC of a WITHDRAW → no mem_wr_en; all outputs 0 immediately; memory unchanged. After release with both requesting, term0 is granted first.

Source files
------------

// File: rtl/atm_txn_arbiter.sv
// atm_txn_arbiter: round-robin serialiser of ATM balance transactions onto a single-port balance memory
module atm_txn_arbiter #(
  parameter int N_TERM    = 2,
  parameter int ACC_COUNT = 10,
  parameter int BAL_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_TERM-1:0]         i_req,
  input  logic [2*N_TERM-1:0]       i_op,
  input  logic [4*N_TERM-1:0]       i_acc,
  input  logic [BAL_W*N_TERM-1:0]   i_amount,
  output logic [N_TERM-1:0]         o_grant,
  output logic [N_TERM-1:0]         o_done,
  output logic [1:0]                o_resp_status,
  output logic [BAL_W-1:0]          o_resp_balance,
  output logic                      o_busy,
  output logic                      o_mem_rd_en,
  output logic                      o_mem_wr_en,
  output logic [3:0]                o_mem_addr,
  output logic [BAL_W-1:0]          o_mem_wr_data,
  input  logic [BAL_W-1:0]          i_mem_rd_data
);
  localparam int IW = $clog2(N_TERM);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_RESP} state_t;
  state_t r_state, w_next;
  logic [N_TERM-1:0] r_grant, r_done_q, w_elig;
  logic [IW-1:0] r_last, r_gidx, w_idx;
  logic [IW:0] w_pos;
  logic w_found, w_sel_bad, w_insuf, w_wd_ok, w_dep_ok;
  logic [1:0] r_op, r_status, w_sel_op;
  logic [3:0] r_acc, w_sel_acc;
  logic [BAL_W-1:0] r_amt, r_result, w_sel_amt;
  logic [BAL_W:0] w_sum;
  assign w_sel_op  = i_op[2*int'(w_idx) +: 2];
  assign w_sel_acc = i_acc[4*int'(w_idx) +: 4];
  assign w_sel_amt = i_amount[BAL_W*int'(w_idx) +: BAL_W];
  assign w_sel_bad = (int'(w_sel_acc) >= ACC_COUNT) || (w_sel_op == 2'd3);
  assign w_sum     = {1'b0, i_mem_rd_data} + {1'b0, r_amt};
  assign w_insuf   = r_amt > i_mem_rd_data;
  assign w_wd_ok   = (r_op == 2'd1) && !w_insuf;
  assign w_dep_ok  = (r_op == 2'd2) && !w_sum[BAL_W];
  // round-robin pick: first eligible terminal after last_grant, skipping the one just completed
  always_comb begin
    w_elig  = i_req & ~r_done_q;
    w_found = 1'b0;
    w_idx   = '0;
    w_pos   = '0;
    for (int k = N_TERM; k >= 1; k--) begin
      w_pos = {1'b0, r_last} + (IW+1)'(k);
      w_pos = (w_pos >= (IW+1)'(N_TERM)) ? w_pos - (IW+1)'(N_TERM) : w_pos;
      if (w_elig[w_pos[IW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_pos[IW-1:0];
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = !w_found ? S_IDLE : w_sel_bad ? S_RESP : S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = (w_wd_ok || w_dep_ok) ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  // transaction latch, read-modify-write result and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant  <= '0;
      r_done_q <= '0;
      r_last   <= IW'(N_TERM - 1);
      r_gidx   <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_amt    <= '0;
      r_status <= '0;
      r_result <= '0;
    end else begin
      r_done_q <= o_done;
      if (r_state == S_IDLE && w_found) begin
        r_grant  <= N_TERM'(1) << w_idx;
        r_gidx   <= w_idx;
        r_op     <= w_sel_op;
        r_acc    <= w_sel_acc;
        r_amt    <= w_sel_amt;
        r_status <= w_sel_bad ? 2'd3 : 2'd0;
        r_result <= '0;
      end else if (r_state == S_EXEC) begin
        r_result <= w_wd_ok ? i_mem_rd_data - r_amt : w_dep_ok ? w_sum[BAL_W-1:0] : i_mem_rd_data;
        r_status <= (r_op == 2'd1 && w_insuf) ? 2'd1 : (r_op == 2'd2 && w_sum[BAL_W]) ? 2'd2 : 2'd0;
      end else if (r_state == S_RESP) begin
        r_last  <= r_gidx;
        r_grant <= '0;
      end
    end
  end
  // outputs decoded from state; response fields read zero outside the done cycle
  always_comb begin
    o_busy         = r_state != S_IDLE;
    o_grant        = r_grant;
    o_done         = (r_state == S_RESP) ? r_grant : '0;
    o_resp_status  = (r_state == S_RESP) ? r_status : 2'd0;
    o_resp_balance = (r_state == S_RESP) ? r_result : '0;
    o_mem_rd_en    = r_state == S_READ;
    o_mem_wr_en    = r_state == S_WRITE;
    o_mem_addr     = (r_state == S_READ || r_state == S_WRITE) ? r_acc : 4'd0;
    o_mem_wr_data  = (r_state == S_WRITE) ? r_result : '0;
  end
endmodule

// File: tb/tb_atm_txn_arbiter.sv
// tb_atm_txn_arbiter: directed plan plus randomized transactions checked against a bank-ledger model
module tb_atm_txn_arbiter;
  localparam int N = 3;
  localparam int AC = 10;
  localparam int BW = 32;
  logic clk = 0;
  logic rst = 0;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] op = '0;
  logic [4*N-1:0] acc = '0;
  logic [BW*N-1:0] amount = '0;
  logic [N-1:0] grant, done;
  logic [1:0] resp_status;
  logic [BW-1:0] resp_balance, mem_wr_data, rd_data;
  logic busy, mem_rd_en, mem_wr_en;
  logic [3:0] mem_addr;
  logic [BW-1:0] mem [16];
  logic pre_en = 0;
  logic [3:0] pre_addr = '0;
  logic [BW-1:0] pre_data = '0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [3:0] last_rd_addr = '0;
  logic [BW-1:0] last_wr_data = '0;
  int n_tests = 0;
  int n_fail = 0;
  logic [BW-1:0] ref_bal [AC];
  int model_last;

  atm_txn_arbiter #(.N_TERM(N), .ACC_COUNT(AC), .BAL_W(BW)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_op(op), .i_acc(acc), .i_amount(amount),
    .o_grant(grant), .o_done(done), .o_resp_status(resp_status), .o_resp_balance(resp_balance),
    .o_busy(busy), .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_wr_data(mem_wr_data), .i_mem_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_rd_en) begin
      rd_data <= mem[mem_addr];
      rd_cnt <= rd_cnt + 1;
      last_rd_addr <= mem_addr;
    end
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
      last_wr_data <= mem_wr_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_term(input int t, input logic [1:0] o, input logic [3:0] a, input logic [31:0] m);
    op[2*t +: 2] = o;
    acc[4*t +: 4] = a;
    amount[BW*t +: BW] = m;
  endtask

  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en = 0;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 60);
    if (done == '0) chk("done_timeout", 1, 0);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ctl"}, {grant, done, resp_status, busy, mem_rd_en, mem_wr_en, mem_addr}, 0);
    chk({tag, "_bal"}, resp_balance, 0);
    chk({tag, "_wdata"}, mem_wr_data, 0);
  endtask

  task automatic txn(input int t, input logic [1:0] o, input logic [3:0] a, input logic [31:0] m,
                     input logic [1:0] es, input logic [31:0] eb, input int elat, input int erd, input int ewr);
    int n, r0, w0;
    @(negedge clk);
    @(negedge clk);
    set_term(t, o, a, m);
    req[t] = 1;
    r0 = rd_cnt;
    w0 = wr_cnt;
    wait_done(n);
    chk("latency", n, elat);
    chk("done", done, 1 << t);
    chk("grant", grant, 1 << t);
    chk("status", resp_status, es);
    chk("balance", resp_balance, eb);
    chk("rd_count", rd_cnt - r0, erd);
    chk("wr_count", wr_cnt - w0, ewr);
    req[t] = 0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      int i = (last + k) % N;
      if (p[i]) return i;
    end
    return 0;
  endfunction

  task automatic model(input logic [1:0] o, input logic [3:0] a, input logic [31:0] m,
                       output int st, output logic [31:0] res);
    logic [63:0] s;
    int ai = int'(a);
    st = 0;
    res = 0;
    if (ai >= AC || o == 2'd3) st = 3;
    else if (o == 2'd0) res = ref_bal[ai];
    else if (o == 2'd1) begin
      if (m > ref_bal[ai]) begin
        st = 1;
        res = ref_bal[ai];
      end else begin
        ref_bal[ai] = ref_bal[ai] - m;
        res = ref_bal[ai];
      end
    end else begin
      s = 64'(ref_bal[ai]) + 64'(m);
      if (s > 64'hFFFF_FFFF) begin
        st = 2;
        res = ref_bal[ai];
      end else begin
        ref_bal[ai] = s[31:0];
        res = ref_bal[ai];
      end
    end
  endtask

  task automatic batch();
    logic [N-1:0] pend;
    logic [1:0] bo [N];
    logic [3:0] ba [N];
    logic [31:0] bm [N];
    logic [31:0] b, res;
    int e, n, st;
    @(negedge clk);
    @(negedge clk);
    pend = N'($urandom_range(1, (1 << N) - 1));
    for (int t = 0; t < N; t++) begin
      bo[t] = 2'($urandom_range(0, 3));
      ba[t] = 4'($urandom_range(0, 11));
      b = (int'(ba[t]) < AC) ? ref_bal[int'(ba[t])] : 32'd0;
      case ($urandom_range(0, 3))
        0: bm[t] = $urandom_range(0, 3000);
        1: bm[t] = b;
        2: bm[t] = $urandom;
        default: bm[t] = 32'hFFFF_FFFF - b + 32'($urandom_range(0, 1));
      endcase
      if (pend[t]) set_term(t, bo[t], ba[t], bm[t]);
    end
    req = pend;
    n = 0;
    while (pend != '0 && n < 200) begin
      @(negedge clk);
      n++;
      chk("mem_excl", {mem_rd_en, mem_wr_en} == 2'b11, 0);
      if (done != '0) begin
        e = rr_pick(pend, model_last);
        chk("rr_done", done, 1 << e);
        model(bo[e], ba[e], bm[e], st, res);
        chk("r_status", resp_status, st);
        chk("r_balance", resp_balance, res);
        model_last = e;
        pend[e] = 0;
        req[e] = 0;
      end else if (grant != '0) begin
        for (int t = 0; t < N; t++)
          if (grant[t]) begin
            set_term(t, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 3) == 0) req[t] = 0;
          end
      end
    end
    chk("batch_timeout", pend, 0);
  endtask

  initial begin
    int n, w0;
    logic [31:0] v;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    rst = 1;
    // BALANCE
    poke(2, 3000);
    txn(0, 2'd0, 2, 0, 2'd0, 3000, 3, 1, 0);
    chk("rd_addr", last_rd_addr, 2);
    // WITHDRAW sequence on acc 0
    poke(0, 1000);
    txn(0, 2'd1, 0, 500, 2'd0, 500, 4, 1, 1);
    chk("wr_data", last_wr_data, 500);
    txn(0, 2'd1, 0, 600, 2'd1, 500, 3, 1, 0);
    txn(0, 2'd1, 0, 500, 2'd0, 0, 4, 1, 1);
    chk("mem0_zero", mem[0], 0);
    // DEPOSIT overflow boundary
    poke(3, 32'hFFFF_FFFF);
    txn(1, 2'd2, 3, 1, 2'd2, 32'hFFFF_FFFF, 3, 1, 0);
    poke(4, 0);
    txn(1, 2'd2, 4, 32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFF, 4, 1, 1);
    chk("mem4_max", mem[4], 32'hFFFF_FFFF);
    // bad requests
    txn(0, 2'd1, 10, 5, 2'd3, 0, 1, 0, 0);
    txn(1, 2'd3, 1, 5, 2'd3, 0, 1, 0, 0);
    // contention after reset
    rst_pulse();
    poke(5, 6000);
    @(negedge clk);
    set_term(0, 2'd2, 5, 100);
    set_term(1, 2'd2, 5, 100);
    req = 3'b011;
    wait_done(n);
    chk("cont_done0", done, 1);
    chk("cont_bal0", resp_balance, 6100);
    req[0] = 0;
    wait_done(n);
    chk("cont_done1", done, 2);
    chk("cont_bal1", resp_balance, 6200);
    req[1] = 0;
    // continuous re-requests alternate
    @(negedge clk);
    @(negedge clk);
    set_term(0, 2'd0, 5, 0);
    set_term(1, 2'd0, 5, 0);
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      chk("alt_done", done, (i % 2 == 0) ? 1 : 2);
      if (i > 0) chk("alt_gap", n, 4);
    end
    req = '0;
    // sole requester is re-served after one extra IDLE cycle
    @(negedge clk);
    @(negedge clk);
    req = 3'b001;
    wait_done(n);
    wait_done(n);
    chk("sole_done", done, 1);
    chk("sole_gap", n, 5);
    req = '0;
    // reset during EXEC of a WITHDRAW
    poke(0, 1000);
    @(negedge clk);
    @(negedge clk);
    set_term(0, 2'd1, 0, 100);
    req = 3'b001;
    w0 = wr_cnt;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("exec_busy", busy, 1);
    rst = 0;
    #1;
    chk_zero_outs("async_rst");
    set_term(1, 2'd0, 2, 0);
    req = 3'b011;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("post_rst_grant", grant, 1);
    chk("post_rst_nowr", wr_cnt - w0, 0);
    chk("post_rst_mem0", mem[0], 1000);
    wait_done(n);
    chk("post_rst_bal0", resp_balance, 900);
    req[0] = 0;
    wait_done(n);
    chk("post_rst_done1", done, 2);
    chk("post_rst_bal1", resp_balance, 3000);
    req = '0;
    // randomized transactions against the ledger model
    rst_pulse();
    model_last = N - 1;
    for (int a = 0; a < AC; a++) begin
      case ($urandom_range(0, 3))
        0: v = 0;
        1: v = $urandom_range(0, 5000);
        2: v = $urandom;
        default: v = 32'hFFFF_FFFF - 32'($urandom_range(0, 100));
      endcase
      poke(4'(a), v);
      ref_bal[a] = v;
    end
    repeat (150) batch();
    @(negedge clk);
    @(negedge clk);
    for (int a = 0; a < AC; a++) chk("final_mem", mem[a], ref_bal[a]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
